// File: rtl/vmem_pkg.sv
// Shared constants, state encoding and fault helper for the level-2 virtual memory map stage.
package vmem_pkg;

    localparam int VMEM_L2_ADDR_W = 10;
    localparam int VMEM_L2_DATA_W = 24;

    localparam int VMO_ACCESS_BIT = 23;
    localparam int VMO_WRITE_BIT  = 22;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } vmem_l2_state_t;

    // {pfr, pfw}: access bit clear faults any read; write bit clear faults a write access.
    function automatic logic [1:0] vmem_l2_faults(
        input logic                      rd,
        input logic                      wr,
        input logic [VMEM_L2_DATA_W-1:0] word
    );
        logic pfr_f;
        logic pfw_f;
        pfr_f = rd & ~word[VMO_ACCESS_BIT];
        pfw_f = rd & wr & ~word[VMO_WRITE_BIT];
        return {pfr_f, pfw_f};
    endfunction

endpackage

// File: rtl/vmem_l2_ram.sv
// Single-port map RAM: read-first, registered output that holds while disabled.
module vmem_l2_ram
    import vmem_pkg::*;
#(
    parameter int ADDR_WIDTH = VMEM_L2_ADDR_W,
    parameter int DATA_WIDTH = VMEM_L2_DATA_W,
    parameter int DEPTH      = 1 << VMEM_L2_ADDR_W
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Old contents are captured before the write lands, so a same-entry
    // read/write returns the previous word.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/vmem_l2_map.sv
// Level-2 virtual memory map: {vmap, mapi[12:8]} indexes a 1024x24 map RAM,
// producing the map word and page-fault flags two cycles after the request.
module vmem_l2_map
    import vmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = VMEM_L2_ADDR_W,
    parameter int DATA_WIDTH     = VMEM_L2_DATA_W,
    parameter int DEPTH          = 1 << VMEM_L2_ADDR_W,
    parameter bit SCRUB_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            vmap,
    input  logic [23:8]           mapi,
    input  logic [31:0]           vma,
    input  logic                  vm1rp,
    input  logic                  vm1wp,
    input  logic                  acc_wr,
    output logic [DATA_WIDTH-1:0] vmo,
    output logic                  vmo_valid,
    output logic                  pfr,
    output logic                  pfw,
    output logic                  busy
);

    vmem_l2_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] scrub_cnt_q, scrub_cnt_d;
    logic                  scrub_we;

    logic [4:0]            mapi_p0;
    logic [DATA_WIDTH-1:0] vma_p0;
    logic                  rp_p0;
    logic                  wp_p0;
    logic                  wr_p0;

    logic                  vld_p1;
    logic                  acc_p1;
    logic                  wr_p1;
    logic [DATA_WIDTH-1:0] vmo_hold_p1;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [1:0]            faults;

    logic                  unused_bits;
    assign unused_bits = ^{vma[31:24], mapi[23:13]};

    // Scrub FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCRUB_ON_RESET ? SCRUB : IDLE;
            scrub_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        scrub_we    = 1'b0;
        case (state_q)
            SCRUB: begin
                scrub_we = 1'b1;
                if (scrub_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    scrub_cnt_d = scrub_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SCRUB);

    // Stage A (p0): request capture, suppressed while scrubbing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mapi_p0 <= '0;
            vma_p0  <= '0;
            rp_p0   <= 1'b0;
            wp_p0   <= 1'b0;
            wr_p0   <= 1'b0;
        end else begin
            rp_p0 <= vm1rp & ~busy;
            wp_p0 <= vm1wp & ~busy;
            wr_p0 <= acc_wr & ~busy;
            if (!busy) begin
                mapi_p0 <= mapi[12:8];
                vma_p0  <= vma[DATA_WIDTH-1:0];
            end
        end
    end

    // Stage B: RAM access; scrub owns the port while busy, and stage A is empty then
    always_comb begin
        ram_en    = rp_p0 | wp_p0;
        ram_we    = wp_p0;
        ram_addr  = {vmap, mapi_p0};
        ram_wdata = vma_p0;
        if (scrub_we) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = scrub_cnt_q;
            ram_wdata = '0;
        end
    end

    vmem_l2_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Stage C (p1): result qualifiers travel with the RAM output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            acc_p1      <= 1'b0;
            wr_p1       <= 1'b0;
            vmo_hold_p1 <= '0;
        end else begin
            vld_p1      <= rp_p0;
            acc_p1      <= rp_p0 | wp_p0;
            wr_p1       <= rp_p0 & wr_p0;
            vmo_hold_p1 <= vmo;
        end
    end

    // Scrub also clocks the RAM output, so vmo only follows it after a user access.
    assign vmo       = acc_p1 ? ram_rdata : vmo_hold_p1;
    assign faults    = vmem_l2_faults(vld_p1, wr_p1, ram_rdata);
    assign vmo_valid = vld_p1;
    assign pfr       = faults[1];
    assign pfw       = faults[0];

endmodule

// File: tb/tb_vmem_l2_map.sv
// Bench for vmem_l2_map: scrub timing, directed map accesses and randomized traffic vs. a reference model.
module tb_vmem_l2_map;
    import vmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  vmap;
    logic [23:8] mapi;
    logic [31:0] vma;
    logic        vm1rp, vm1wp, acc_wr;
    logic [23:0] vmo;
    logic        vmo_valid, pfr, pfw, busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [23:0] v;
        logic        vld;
        logic        pr;
        logic        pw;
    } exp_t;

    exp_t        expq[$];
    logic [23:0] model_mem [1024];
    logic [23:0] last_vmo;
    logic [4:0]  pend_vmap;

    vmem_l2_map dut (
        .clk       (clk),
        .reset     (reset),
        .vmap      (vmap),
        .mapi      (mapi),
        .vma       (vma),
        .vm1rp     (vm1rp),
        .vm1wp     (vm1wp),
        .acc_wr    (acc_wr),
        .vmo       (vmo),
        .vmo_valid (vmo_valid),
        .pfr       (pfr),
        .pfw       (pfw),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request cycle: check the result due now (issued two steps ago), drive
    // this request plus vmap for the previous one, and update the model.
    task automatic step(input logic rp, input logic wp, input logic wr,
                        input logic [9:0] idx, input logic [23:0] data);
        exp_t        e;
        exp_t        due;
        logic [23:0] old;
        @(negedge clk);
        due = expq.pop_front();
        chk("vmo", 32'(vmo), 32'(due.v));
        chk("vmo_valid", 32'(vmo_valid), 32'(due.vld));
        chk("pfr", 32'(pfr), 32'(due.pr));
        chk("pfw", 32'(pfw), 32'(due.pw));
        vmap       = pend_vmap;
        mapi       = 16'($urandom);
        mapi[12:8] = idx[4:0];
        vma        = {8'($urandom), data};
        vm1rp      = rp;
        vm1wp      = wp;
        acc_wr     = wr;
        pend_vmap  = idx[9:5];
        old = model_mem[idx];
        if (rp || wp) last_vmo = old;
        if (wp) model_mem[idx] = data;
        e.v   = last_vmo;
        e.vld = rp;
        e.pr  = rp && !old[23];
        e.pw  = rp && wr && !old[22];
        expq.push_back(e);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 10'h000, 24'h0);
    endtask

    initial begin
        int n;
        exp_t z;
        reset  = 1'b1;
        vmap   = '0;
        mapi   = '0;
        vma    = '0;
        vm1rp  = 1'b0;
        vm1wp  = 1'b0;
        acc_wr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_vmo", 32'(vmo), 32'h0);
        chk("rst_vmo_valid", 32'(vmo_valid), 32'h0);
        chk("rst_pfr", 32'(pfr), 32'h0);
        chk("rst_pfw", 32'(pfw), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);

        // Partial scrub, with a write attempted while busy, then reset at cycle 500.
        reset = 1'b0;
        for (int i = 0; i < 500; i++) begin
            vm1wp = (i == 100);
            if (i == 100) begin
                mapi[12:8] = 5'h15;
                vma        = 32'h00FF_FFFF;
            end
            if (i == 101) vmap = 5'h02;
            @(negedge clk);
        end
        chk("mid_scrub_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_mid_scrub_busy", 32'(busy), 32'h1);
        repeat (2) @(negedge clk);

        // Full scrub: count busy cycles, attempt a write to idx 0x0AA while busy.
        reset = 1'b0;
        n = 0;
        for (int guard = 0; guard < 2000 && busy; guard++) begin
            chk("scrub_vmo_valid", 32'(vmo_valid), 32'h0);
            vm1wp = (n == 10);
            if (n == 10) begin
                mapi[12:8] = 5'h0A;
                vma        = 32'h00AB_CDEF;
            end
            if (n == 11) vmap = 5'h05;
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'd1024);
        chk("busy_after_scrub", 32'(busy), 32'h0);

        for (int i = 0; i < 1024; i++) model_mem[i] = 24'h0;
        last_vmo  = 24'h0;
        pend_vmap = 5'h0;
        z.v = 24'h0; z.vld = 1'b0; z.pr = 1'b0; z.pw = 1'b0;
        expq.push_back(z);
        expq.push_back(z);

        // Scrubbed corners, then the directed map cases.
        step(1, 0, 0, 10'h000, 24'h0);
        step(1, 0, 0, 10'h3FF, 24'h0);
        step(0, 1, 0, 10'h343, 24'hC00123);
        step(0, 1, 0, 10'h010, 24'h800456);
        idle_step();
        step(1, 0, 1, 10'h343, 24'h0);
        step(1, 0, 1, 10'h010, 24'h0);
        step(1, 0, 0, 10'h010, 24'h0);
        idle_step();
        step(1, 1, 1, 10'h343, 24'h400777);
        step(1, 0, 1, 10'h343, 24'h0);
        step(1, 0, 0, 10'h0AA, 24'h0);
        step(1, 0, 0, 10'h055, 24'h0);
        idle_step();
        idle_step();

        // Back-to-back: fill 0x001..0x008, then read them every cycle.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 10'(i), 24'h111111 * 24'(i) ^ 24'h400000);
        for (int i = 1; i <= 8; i++) step(1, 0, i[0], 10'(i), 24'h0);
        idle_step();
        idle_step();
        idle_step();

        // Randomized traffic over a small index set to force collisions.
        for (int i = 0; i < 400; i++) begin
            logic [9:0] idx;
            idx = {($urandom_range(0, 1) != 0) ? 5'h1F : 5'h00, 5'($urandom_range(0, 7))};
            step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                 1'($urandom_range(0, 1)), idx, 24'($urandom));
        end
        idle_step();
        idle_step();
        idle_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
